// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   ILEN          instruction word width
//   PC_W          program counter width used by fetch_entry_t
//   INSTR_BYTES   PC increment per fetched word
//   fetch_entry_t buffered instruction word paired with its PC
package fetch_pkg;
  localparam int ILEN        = 32;
  localparam int PC_W        = 32;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [ILEN-1:0] data;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// Bus bundle for the fetch stage: instruction-memory req/gnt/rvalid channel
// plus the valid/ready channel towards decode.
//   master : fetch unit side (drives imem_req/addr, instr_valid/data/pc)
//   slave  : memory + decode side
interface fetch_if import fetch_pkg::*; #(
  parameter int XLEN = PC_W
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [ILEN-1:0] imem_rdata;
  logic            instr_valid;
  logic            instr_ready;
  logic [ILEN-1:0] instr_data;
  logic [XLEN-1:0] instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_data, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_data, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used both as the instruction buffer and as the
// in-order tag queue of outstanding request PCs.
//   clk, rst_n  clock, async active-low reset (storage cleared to zero)
//   flush       empties the FIFO; wins over push and pop in the same cycle
//   push/wdata  write one entry (dropped if full and not popping)
//   pop         remove head entry (ignored when empty)
//   rdata       head entry (registered storage, no input->output path)
//   count       current occupancy
module fetch_fifo import fetch_pkg::*; #(
  parameter type T     = fetch_entry_t,
  parameter int  DEPTH = 2,
  parameter int  CW    = $clog2(DEPTH+1)
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  T              wdata,
  input  logic          pop,
  output T              rdata,
  output logic [CW-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T              mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
  endfunction

  assign do_pop  = pop && (cnt_q != '0);
  assign do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wp_q] <= wdata;
        wp_q        <= inc(wp_q);
      end
      if (do_pop) rp_q <= inc(rp_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign rdata = mem_q[rp_q];
  assign count = cnt_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the PC, issues word fetches to instruction
// memory, buffers returned words with their PC and hands them to decode.
// Taken jumps/branches redirect the PC; responses already in flight at that
// point are dropped via a discard counter. Static predict-not-taken.
//   clk, rst_n        clock, async active-low reset
//   jack, je          jump/branch resolved / taken (redirect = jack && je)
//   jump_target       redirect address, low two bits ignored
//   bus (master)      imem_req/addr/gnt/rvalid/rdata, instr_valid/ready/data/pc
// XLEN must equal fetch_pkg::PC_W (width of the buffered PC field).
module fetch_unit import fetch_pkg::*; #(
  parameter int              XLEN         = PC_W,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              BUF_DEPTH    = 2
)(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            jack,
  input  logic            je,
  input  logic [XLEN-1:0] jump_target,
  fetch_if.master         bus
);
  localparam int CW = $clog2(BUF_DEPTH+1);

  logic [XLEN-1:0] pc_q, pc_d;      // address of current/next request
  logic [XLEN-1:0] rpc_q, rpc_d;    // target parked behind a held request
  logic            req_q, req_d;
  logic            pend_q, pend_d;  // redirect waiting for held request's gnt
  logic [CW-1:0]   disc_q, disc_d;  // responses still to be thrown away
  logic [CW-1:0]   out_cnt, out_d;  // outstanding = tag queue occupancy
  logic [CW-1:0]   buf_cnt, buf_d;

  logic            redirect, held, gnt_fire, rv_fire, drop, push, pop;
  logic [XLEN-1:0] target, tag_pc;
  fetch_entry_t    buf_wdata, buf_head;

  assign redirect = jack && je;
  assign target   = jump_target & ~XLEN'(INSTR_BYTES-1);
  assign held     = req_q && !bus.imem_gnt;
  assign gnt_fire = req_q && bus.imem_gnt;
  assign rv_fire  = bus.imem_rvalid && (out_cnt != '0);
  assign drop     = rv_fire && (disc_q != '0);
  // A word arriving in the redirect cycle is stale too; the flush eats it.
  assign push     = rv_fire && !drop && !redirect;
  assign pop      = bus.instr_valid && bus.instr_ready;

  // PC of every granted request, popped in order as responses return.
  fetch_fifo #(.T(logic [XLEN-1:0]), .DEPTH(BUF_DEPTH)) u_tagq (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .push(gnt_fire), .wdata(pc_q), .pop(rv_fire),
    .rdata(tag_pc), .count(out_cnt)
  );

  assign buf_wdata.pc   = tag_pc;
  assign buf_wdata.data = bus.imem_rdata;

  fetch_fifo #(.DEPTH(BUF_DEPTH)) u_buf (
    .clk(clk), .rst_n(rst_n), .flush(redirect),
    .push(push), .wdata(buf_wdata), .pop(pop),
    .rdata(buf_head), .count(buf_cnt)
  );

  always_comb begin
    pc_d   = pc_q;
    rpc_d  = rpc_q;
    pend_d = pend_q;
    out_d  = out_cnt + CW'(gnt_fire) - CW'(rv_fire);
    buf_d  = redirect ? '0 : buf_cnt + CW'(push) - CW'(pop);

    if (gnt_fire) begin
      pc_d   = pend_q ? rpc_q : pc_q + XLEN'(INSTR_BYTES);
      pend_d = 1'b0;
    end
    if (redirect) begin
      if (held) begin
        // Request must stay stable until granted; target goes out after it.
        pend_d = 1'b1;
        rpc_d  = target;
      end else begin
        pc_d   = target;
        pend_d = 1'b0;
      end
    end

    // On redirect every response still in flight is stale. A held request
    // granted later under a pending redirect adds one more.
    if (redirect) disc_d = out_d;
    else          disc_d = disc_q - CW'(drop) + CW'(pend_q && gnt_fire);

    // Credit: every outstanding response is guaranteed a buffer slot.
    req_d = held || ((int'(out_d) + int'(buf_d)) < BUF_DEPTH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_VECTOR;
      rpc_q  <= '0;
      req_q  <= 1'b0;
      pend_q <= 1'b0;
      disc_q <= '0;
    end else begin
      pc_q   <= pc_d;
      rpc_q  <= rpc_d;
      req_q  <= req_d;
      pend_q <= pend_d;
      disc_q <= disc_d;
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = (buf_cnt != '0);
  assign bus.instr_data  = buf_head.data;
  assign bus.instr_pc    = buf_head.pc;
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RV    = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jack = 1'b0, je = 1'b0;
  logic [31:0] jump_target = '0;

  fetch_if #(.XLEN(XLEN)) bus();

  fetch_unit #(.XLEN(XLEN), .RESET_VECTOR(RV), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .jack(jack), .je(je),
    .jump_target(jump_target), .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  // Reference: program order is a straight line of word PCs from the last
  // reset/redirect point; data is a fixed function of the address.
  logic [31:0] exp_q[$];
  task automatic restart(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 1024; i++) exp_q.push_back(start + 32'(4*i));
  endtask

  // ---------------- instruction memory model ----------------
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t       pq[$];
  int          cyc = 0, n_gnt = 0;
  int          gnt_pct = 100, lat_lo = 0, lat_hi = 0;
  logic        blk_en = 1'b0;
  logic [31:0] blk_addr = '0;

  initial begin : imem
    logic        s_fire, s_rv;
    logic [31:0] s_addr;
    pend_t       p;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    forever begin
      @(negedge clk);
      s_fire = rst_n && bus.imem_req && bus.imem_gnt;
      s_addr = bus.imem_addr;
      s_rv   = rst_n && bus.imem_rvalid;
      @(posedge clk); #1;
      cyc++;
      if (!rst_n) begin
        pq.delete();
        bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0;
        continue;
      end
      if (s_rv && pq.size() > 0) void'(pq.pop_front());
      if (s_fire) begin
        p.addr = s_addr;
        p.due  = cyc + int'($urandom_range(lat_hi, lat_lo));
        pq.push_back(p);
        n_gnt++;
      end
      if (pq.size() > 0 && pq[0].due <= cyc) begin
        bus.imem_rvalid = 1'b1; bus.imem_rdata = memf(pq[0].addr);
      end else begin
        bus.imem_rvalid = 1'b0; bus.imem_rdata = $urandom;
      end
      bus.imem_gnt = !(blk_en && bus.imem_addr == blk_addr) &&
                     (int'($urandom_range(99, 0)) < gnt_pct);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int          xfers = 0;
  logic [31:0] last_pc = '0;

  initial begin : monitor
    logic        pv = 0, prdy = 0, predir = 0, pheld = 0;
    logic [31:0] ppc = 0, pdata = 0, paddr = 0, e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin pv = 0; pheld = 0; continue; end
      if (pv && !prdy && !predir) begin
        chk("stall_valid", bus.instr_valid, 1'b1);
        chk("stall_pc", bus.instr_pc, ppc);
        chk("stall_data", bus.instr_data, pdata);
      end
      if (pheld) begin
        chk("req_held", bus.imem_req, 1'b1);
        chk("addr_held", bus.imem_addr, paddr);
      end
      chk("credit", (pq.size() + int'(bus.instr_valid)) <= DEPTH, 1'b1);
      if (bus.instr_valid && bus.instr_ready && !(jack && je)) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_empty: got pc %0h expected none", bus.instr_pc);
        end else begin
          e = exp_q.pop_front();
          chk("instr_pc", bus.instr_pc, e);
          chk("instr_data", bus.instr_data, memf(e));
        end
        xfers++;
        last_pc = bus.instr_pc;
      end
      pv = bus.instr_valid; prdy = bus.instr_ready; predir = jack && je;
      ppc = bus.instr_pc; pdata = bus.instr_data;
      pheld = bus.imem_req && !bus.imem_gnt; paddr = bus.imem_addr;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_redirect(input logic [31:0] t);
    jump_target = t; jack = 1'b1; je = 1'b1;
    restart(t & 32'hFFFF_FFFC);
    cycles(1);
    jack = 1'b0; je = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req", bus.imem_req, 1'b0);
    chk("rst_addr", bus.imem_addr, RV);
    chk("rst_valid", bus.instr_valid, 1'b0);
    chk("rst_data", bus.instr_data, 32'h0);
    chk("rst_pc", bus.instr_pc, 32'h0);
    cycles(2);
    restart(RV);
    rst_n = 1'b1;
    #1;
    chk("req_before_edge", bus.imem_req, 1'b0);
    cycles(1);
    chk("req_first", bus.imem_req, 1'b1);
    chk("addr_first", bus.imem_addr, RV);
  endtask

  task automatic wait_xfers(input int n, input string nm);
    int x0;
    x0 = xfers;
    for (int k = 0; k < 80 && xfers < x0 + n; k++) cycles(1);
    chk(nm, xfers >= x0 + n, 1'b1);
  endtask

  initial begin : stim
    int g0, g1, r;
    bus.instr_ready = 1'b0;
    cycles(1);
    do_reset();

    // straight-line fetch, 1-cycle memory, decode always ready
    bus.instr_ready = 1'b1;
    wait_xfers(4, "t1_four_xfers");

    // decode back-pressure
    bus.instr_ready = 1'b0;
    @(negedge clk); g0 = n_gnt;
    repeat (10) @(negedge clk);
    g1 = n_gnt;
    chk("stall_gnts", (g1 - g0) <= DEPTH, 1'b1);
    chk("stall_full_valid", bus.instr_valid, 1'b1);
    cycles(1);
    bus.instr_ready = 1'b1;
    wait_xfers(3, "t2_resume");

    // redirect with two requests in flight
    lat_lo = 2; lat_hi = 2;
    for (int k = 0; k < 50 && pq.size() != 2; k++) cycles(1);
    chk("t3_two_out", pq.size(), 2);
    do_redirect(32'h100);
    wait_xfers(1, "t3_xfer");
    chk("t3_first_pc", last_pc, 32'h100);

    // redirect while the request at 0x8 is held ungranted
    lat_lo = 0; lat_hi = 0; blk_en = 1'b1; blk_addr = 32'h8;
    do_reset();
    for (int k = 0; k < 30 && !(bus.imem_req && bus.imem_addr == 32'h8); k++) cycles(1);
    chk("t4_req_at_8", bus.imem_req && bus.imem_addr == 32'h8, 1'b1);
    do_redirect(32'h100);
    for (int k = 0; k < 3; k++) begin
      chk("t4_hold_req", bus.imem_req, 1'b1);
      chk("t4_hold_addr", bus.imem_addr, 32'h8);
      cycles(1);
    end
    blk_en = 1'b0;
    for (int k = 0; k < 30 && !(bus.imem_req && bus.imem_addr != 32'h8); k++) cycles(1);
    chk("t4_next_addr", bus.imem_addr, 32'h100);
    wait_xfers(1, "t4_xfer");
    chk("t4_first_pc", last_pc, 32'h100);

    // not-taken / stray je, unaligned target, wrap-around
    lat_hi = 1;
    cycles(5);
    jack = 1'b1; cycles(1); jack = 1'b0;
    cycles(3);
    je = 1'b1; cycles(1); je = 1'b0;
    wait_xfers(3, "t5_nt_cont");
    do_redirect(32'h103);
    for (int k = 0; k < 30 && !bus.imem_req; k++) cycles(1);
    chk("t5_addr_align", bus.imem_addr, 32'h100);
    wait_xfers(1, "t5_xfer");
    chk("t5_first_pc", last_pc, 32'h100);
    do_redirect(32'hFFFF_FFF8);
    wait_xfers(4, "t5_wrap_xfers");
    chk("t5_wrap_pc", last_pc, 32'h4);

    // randomized traffic
    gnt_pct = 70; lat_lo = 0; lat_hi = 3;
    for (int i = 0; i < 800; i++) begin
      bus.instr_ready = ($urandom_range(3, 0) != 0);
      r = int'($urandom_range(99, 0));
      if (r < 4) do_redirect(($urandom_range(1, 0) != 0) ? $urandom : 32'h200 + 32'($urandom_range(63, 0)));
      else if (r < 7) begin jack = 1'b1; cycles(1); jack = 1'b0; end
      else if (r < 9) begin je = 1'b1; cycles(1); je = 1'b0; end
      else cycles(1);
    end

    // reset mid-stream with requests outstanding
    bus.instr_ready = 1'b1;
    for (int k = 0; k < 50 && pq.size() == 0; k++) cycles(1);
    chk("t7_outstanding", pq.size() > 0, 1'b1);
    gnt_pct = 100; lat_hi = 0;
    do_reset();
    wait_xfers(1, "t7_xfer");
    chk("t7_first_pc", last_pc, RV);
    wait_xfers(3, "t7_more");

    cycles(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
